// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b word/mask types and data-responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmr_state_t;

    // Old bytes survive where the mask bit is clear, new bytes land where it is set.
    function automatic lc3b_word mergeBytes(input lc3b_word oldWord,
                                            input lc3b_word newWord,
                                            input lc3b_mem_wmask mask);
        lc3b_word merged;
        merged[7:0]  = mask[0] ? newWord[7:0]  : oldWord[7:0];
        merged[15:8] = mask[1] ? newWord[15:8] : oldWord[15:8];
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : responder_ram
// Description : Word array with byte-masked synchronous write and a registered
//               read that can pre-merge pending write data into the result.
// Revision    : 1.0 - initial release
// ============================================================================
module responder_ram
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rdEn,
    input  logic [DEPTH_LOG2-1:0] rdIndex,
    input  lc3b_word              mergeData,
    input  lc3b_mem_wmask         mergeMask,
    output lc3b_word              rdData,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrIndex,
    input  lc3b_word              wrData,
    input  lc3b_mem_wmask         wrMask
);

    lc3b_word r_mem [2**DEPTH_LOG2];
    lc3b_word r_rdData;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            if (wrMask[0]) r_mem[wrIndex][7:0]  <= wrData[7:0];
            if (wrMask[1]) r_mem[wrIndex][15:8] <= wrData[15:8];
        end
        // A zero merge mask makes this a plain registered read.
        if (rdEn) begin
            r_rdData <= mergeBytes(r_mem[rdIndex], mergeData, mergeMask);
        end
    end

    assign rdData = r_rdData;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : LC-3b data-port memory responder with programmable wait states
//               and a single-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  lc3b_word      mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_wdata,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latencyCheck
        $error("data_mem_responder: LATENCY must be within 1..15");
    end

    localparam logic [3:0] c_countLoad = 4'(LATENCY - 1);

    dmr_state_t              r_state, w_nextState;
    logic [3:0]              r_count, w_nextCount;
    logic [DEPTH_LOG2-1:0]   r_index;
    lc3b_word                r_wdata;
    lc3b_mem_wmask           r_mask;
    logic                    r_isWrite;
    logic                    r_rdValid;

    logic                    w_request;
    logic                    w_capture;
    logic                    w_enterResp;
    logic [DEPTH_LOG2-1:0]   w_curIndex;
    lc3b_word                w_curWdata;
    lc3b_mem_wmask           w_curMask;
    logic                    w_curIsWrite;
    lc3b_word                w_ramData;
    logic                    w_unusedAddrBits;

    assign w_request        = mem_read | mem_write;
    assign w_capture        = (r_state == IDLE) && w_request;
    assign w_enterResp      = (w_nextState == RESP) && (r_state != RESP);
    assign w_unusedAddrBits = ^mem_address;

    // With LATENCY=1 the RAM read happens on the capture edge, so the live
    // request fields must feed the RAM while idle.
    assign w_curIndex   = (r_state == IDLE) ? mem_address[DEPTH_LOG2:1] : r_index;
    assign w_curWdata   = (r_state == IDLE) ? mem_wdata                 : r_wdata;
    assign w_curMask    = (r_state == IDLE) ? mem_byte_enable           : r_mask;
    assign w_curIsWrite = (r_state == IDLE) ? mem_write                 : r_isWrite;

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            IDLE: begin
                if (w_request) begin
                    w_nextCount = c_countLoad;
                    w_nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_nextCount = r_count - 4'd1;
                if (r_count == 4'd1) w_nextState = RESP;
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_rdValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_enterResp) r_rdValid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_index   <= mem_address[DEPTH_LOG2:1];
            r_wdata   <= mem_wdata;
            r_mask    <= mem_byte_enable;
            r_isWrite <= mem_write;
        end
    end

    responder_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rdEn      (w_enterResp),
        .rdIndex   (w_curIndex),
        .mergeData (w_curWdata),
        .mergeMask (w_curIsWrite ? w_curMask : 2'b00),
        .rdData    (w_ramData),
        .wrEn      ((r_state == RESP) && r_isWrite),
        .wrIndex   (r_index),
        .wrData    (r_wdata),
        .wrMask    (r_mask)
    );

    assign mem_resp  = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    // The RAM read register has no reset; mask it until the first response.
    assign mem_rdata = r_rdValid ? w_ramData : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for three responder instances (LATENCY 3, 1, 15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    function automatic int latOf(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 15);
    endfunction

    typedef struct {
        logic [15:0] data;
        int          respCyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addrV  [3];
    logic [15:0] wdV    [3];
    logic        rdV    [3];
    logic        wrV    [3];
    logic [1:0]  beV    [3];
    logic        respV  [3];
    logic        busyV  [3];
    logic [15:0] rdataV [3];

    bit          expBusy [3];
    txn_t        expQ    [3][$];
    logic [15:0] model   [3][256];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_LOG2 (8),
            .LATENCY    (latOf(g))
        ) u_dut (
            .clk             (clk),
            .reset           (rst),
            .mem_address     (addrV[g]),
            .mem_read        (rdV[g]),
            .mem_write       (wrV[g]),
            .mem_byte_enable (beV[g]),
            .mem_wdata       (wdV[g]),
            .mem_resp        (respV[g]),
            .mem_rdata       (rdataV[g]),
            .busy            (busyV[g])
        );
    end

    // Monitor: compares every presented response against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            txn_t e;
            if (rst) begin
                checks++;
                if (respV[i] !== 1'b0 || rdataV[i] !== 16'h0000 || busyV[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state inst %0d: resp %b rdata %h busy %b, required 0 0000 0",
                             i, respV[i], rdataV[i], busyV[i]);
                end
            end else begin
                checks++;
                if (busyV[i] !== expBusy[i]) begin
                    errors++;
                    $display("FAIL busy inst %0d cyc %0d: got %b, required %b", i, cyc, busyV[i], expBusy[i]);
                end
                if (respV[i] !== 1'b0) begin
                    checks++;
                    if (expQ[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp inst %0d cyc %0d: resp %b, required 0", i, cyc, respV[i]);
                    end else begin
                        e = expQ[i].pop_front();
                        if (respV[i] !== 1'b1 || rdataV[i] !== e.data || cyc != e.respCyc) begin
                            errors++;
                            $display("FAIL resp_data inst %0d: rdata %h at cyc %0d, required %h at cyc %0d",
                                     i, rdataV[i], cyc, e.data, e.respCyc);
                        end
                    end
                end
            end
        end
    end

    task automatic clearInputs(input int i);
        addrV[i] = 16'h0000; wdV[i] = 16'h0000;
        rdV[i] = 1'b0; wrV[i] = 1'b0; beV[i] = 2'b00;
    endtask

    task automatic waitResp(input int i);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (respV[i] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL resp_timeout inst %0d: no mem_resp, required within 40 cycles", i);
            $fatal(1, "stopping: responder inst %0d hung", i);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; capture is on the next edge.
    task automatic issue(input int i, input logic [15:0] a, input logic rd, input logic wr,
                         input logic [1:0] be, input logic [15:0] d, input bit perturb);
        int          idx;
        logic [15:0] old;
        addrV[i] = a; rdV[i] = rd; wrV[i] = wr; beV[i] = be; wdV[i] = d;
        @(posedge clk); #1;
        idx = (a >> 1) % 256;
        old = model[i][idx];
        if (wr) begin
            model[i][idx] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
        end
        expQ[i].push_back('{data: model[i][idx], respCyc: cyc + latOf(i) - 1});
        expBusy[i] = 1'b1;
        if (perturb) begin
            addrV[i] = 16'($urandom); wdV[i] = 16'($urandom); beV[i] = 2'($urandom);
            rdV[i] = 1'($urandom); wrV[i] = 1'($urandom);
        end
        waitResp(i);
        @(posedge clk); #1;
        expBusy[i] = 1'b0;
        clearInputs(i);
    endtask

    task automatic resetMidWait();
        addrV[0] = 16'h0030; wrV[0] = 1'b1; rdV[0] = 1'b0; beV[0] = 2'b11; wdV[0] = 16'hBEEF;
        @(posedge clk); #1;
        rst = 1'b1;
        clearInputs(0);
        @(negedge clk); @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic randomTraffic(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            int op = $urandom_range(0, 3);
            issue(i, 16'($urandom), (op != 1), (op == 1 || op == 2), 2'($urandom),
                  16'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            clearInputs(i);
            expBusy[i] = 1'b0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Fill every word through random upper address bits (wrap-around aliases).
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 256; w++) begin
                issue(i, {7'($urandom), 8'(w), 1'($urandom)}, 1'b0, 1'b1, 2'b11, 16'($urandom), 1'b0);
            end
        end

        issue(0, 16'h0010, 1'b0, 1'b1, 2'b11, 16'h1234, 1'b0);
        issue(0, 16'h0010, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0);
        issue(0, 16'h0020, 1'b0, 1'b1, 2'b11, 16'hAAAA, 1'b0);
        issue(0, 16'h0020, 1'b0, 1'b1, 2'b01, 16'h55CC, 1'b0);
        issue(0, 16'h0020, 1'b0, 1'b1, 2'b10, 16'h1100, 1'b0);
        issue(0, 16'h0020, 1'b0, 1'b1, 2'b00, 16'hFFFF, 1'b0);
        issue(0, 16'h0020, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(0, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(0, 16'h0020, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(0, 16'h0030, 1'b0, 1'b1, 2'b11, 16'h0000, 1'b0);
        resetMidWait();
        issue(0, 16'h0030, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0);
        issue(0, 16'h0202, 1'b1, 1'b1, 2'b11, 16'h7777, 1'b0);
        issue(0, 16'h0002, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(1, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(1, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(2, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        issue(2, 16'h0010, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);

        for (int i = 0; i < 3; i++) randomTraffic(i, 60);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
